generic_n_way_wb_cache: RTL and testbench

Parametrised N-way set-associative write-back cache with true-LRU replacement, per-line dirty tracking, a one-entry eviction buffer with a valid/ready drain port, and a flush engine that writes back every dirty line. It is the successor to the write-allocate N-way cache. It sits between a datapath master (separate read and write ports, one word per line) and a slower backing store that consumes evictions.

---
 rtl/generic_n_way_wb_cache_if.sv | 30 +++
 rtl/generic_n_way_wb_cache.sv | 171 +++++++++++++++++
 tb/tb_generic_n_way_wb_cache.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/generic_n_way_wb_cache_if.sv
// rtl/generic_n_way_wb_cache_if.sv - datapath, flush and eviction signals of the N-way write-back cache
interface generic_n_way_wb_cache_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  re;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  we;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] in;
    logic [DATA_WIDTH-1:0] out;
    logic                  hit;
    logic                  flush;
    logic                  flush_done;
    logic                  busy;
    logic                  evict_valid;
    logic                  evict_ready;
    logic [ADDR_WIDTH-1:0] evict_addr;
    logic [DATA_WIDTH-1:0] evict_data;

    modport slave (
        input  re, read_addr, we, write_addr, in, flush, evict_ready,
        output out, hit, flush_done, busy, evict_valid, evict_addr, evict_data
    );

    modport master (
        output re, read_addr, we, write_addr, in, flush, evict_ready,
        input  out, hit, flush_done, busy, evict_valid, evict_addr, evict_data
    );
endinterface

// File: rtl/generic_n_way_wb_cache.sv
// rtl/generic_n_way_wb_cache.sv - N-way set-associative write-back cache, true LRU, eviction buffer, flush engine
module generic_n_way_wb_cache #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int ENTRIES    = 8,
    parameter int WAYS       = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    generic_n_way_wb_cache_if.slave  bus
);
    localparam int SETS  = ENTRIES / WAYS;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W;
    localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WAY_W = AGE_W;
    localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic [1:0] {IDLE, EVICT, FLUSH_SCAN, FLUSH_WAIT} state_t;
    state_t state_q, state_n;

    logic             valid_q [SETS][WAYS];
    logic             dirty_q [SETS][WAYS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [DATA_WIDTH-1:0] data_q [SETS][WAYS];
    logic [AGE_W-1:0] age_q   [SETS][WAYS];
    logic [AGE_W-1:0] age_n   [SETS][WAYS];
    logic [PTR_W:0]   scan_q;

    logic [IDX_W-1:0] r_idx, w_idx, scan_set;
    logic [TAG_W-1:0] r_tag, w_tag;
    logic [WAY_W-1:0] rd_way, wr_hit_way, victim, wr_way, scan_way;
    logic [AGE_W-1:0] old_age;
    logic rd_hit, wr_hit, vic_found, rd_go, wr_go, flush_go, evicting;
    logic handshake, scan_end, scan_dirty;

    assign r_idx = bus.read_addr[IDX_W-1:0];
    assign r_tag = bus.read_addr[ADDR_WIDTH-1:IDX_W];
    assign w_idx = bus.write_addr[IDX_W-1:0];
    assign w_tag = bus.write_addr[ADDR_WIDTH-1:IDX_W];

    assign rd_go     = bus.re && (state_q == IDLE || state_q == EVICT);
    assign wr_go     = bus.we && (state_q == IDLE);
    assign flush_go  = bus.flush && !bus.we && (state_q == IDLE);
    assign handshake = bus.evict_valid && bus.evict_ready;
    assign bus.busy  = (state_q != IDLE);

    assign scan_set   = IDX_W'(scan_q / WAYS);
    assign scan_way   = WAY_W'(scan_q % WAYS);
    assign scan_end   = (scan_q == (PTR_W+1)'(ENTRIES));
    assign scan_dirty = valid_q[scan_set][scan_way] && dirty_q[scan_set][scan_way];

    // Read's LRU update is applied first; victim choice and the write's update see its result.
    always_comb begin
        rd_hit     = 1'b0;
        rd_way     = '0;
        wr_hit     = 1'b0;
        wr_hit_way = '0;
        vic_found  = 1'b0;
        victim     = '0;
        old_age    = '0;
        age_n      = age_q;
        for (int i = 0; i < WAYS; i++) begin
            if (valid_q[r_idx][i] && tag_q[r_idx][i] == r_tag) begin
                rd_hit = 1'b1;
                rd_way = WAY_W'(i);
            end
            if (valid_q[w_idx][i] && tag_q[w_idx][i] == w_tag) begin
                wr_hit     = 1'b1;
                wr_hit_way = WAY_W'(i);
            end
        end
        if (rd_go && rd_hit) begin
            old_age = age_q[r_idx][rd_way];
            for (int i = 0; i < WAYS; i++)
                if (age_n[r_idx][i] < old_age) age_n[r_idx][i] = age_n[r_idx][i] + AGE_W'(1);
            age_n[r_idx][rd_way] = '0;
        end
        for (int i = 0; i < WAYS; i++) begin
            if (!valid_q[w_idx][i] && !vic_found) begin
                vic_found = 1'b1;
                victim    = WAY_W'(i);
            end
        end
        if (!vic_found) begin
            for (int i = 0; i < WAYS; i++)
                if (age_n[w_idx][i] == AGE_W'(WAYS-1)) victim = WAY_W'(i);
        end
        wr_way = wr_hit ? wr_hit_way : victim;
        if (wr_go) begin
            old_age = age_n[w_idx][wr_way];
            for (int i = 0; i < WAYS; i++)
                if (age_n[w_idx][i] < old_age) age_n[w_idx][i] = age_n[w_idx][i] + AGE_W'(1);
            age_n[w_idx][wr_way] = '0;
        end
    end

    assign evicting = wr_go && !wr_hit && valid_q[w_idx][victim] && dirty_q[w_idx][victim];

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: begin
                if (evicting)      state_n = EVICT;
                else if (flush_go) state_n = FLUSH_SCAN;
            end
            EVICT:      if (handshake) state_n = IDLE;
            FLUSH_SCAN: begin
                if (scan_end)        state_n = IDLE;
                else if (scan_dirty) state_n = FLUSH_WAIT;
            end
            FLUSH_WAIT: if (handshake) state_n = FLUSH_SCAN;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            scan_q          <= '0;
            bus.out         <= '0;
            bus.hit         <= 1'b0;
            bus.flush_done  <= 1'b0;
            bus.evict_valid <= 1'b0;
            bus.evict_addr  <= '0;
            bus.evict_data  <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    data_q[s][w]  <= '0;
                    age_q[s][w]   <= AGE_W'(w);
                end
            end
        end else begin
            state_q        <= state_n;
            age_q          <= age_n;
            bus.flush_done <= 1'b0;
            bus.hit        <= rd_go && rd_hit;
            bus.out        <= (rd_go && rd_hit) ? data_q[r_idx][rd_way] : '0;
            if (handshake) bus.evict_valid <= 1'b0;
            if (wr_go) begin
                if (evicting) begin
                    bus.evict_valid <= 1'b1;
                    bus.evict_addr  <= {tag_q[w_idx][victim], w_idx};
                    bus.evict_data  <= data_q[w_idx][victim];
                end
                valid_q[w_idx][wr_way] <= 1'b1;
                dirty_q[w_idx][wr_way] <= 1'b1;
                tag_q[w_idx][wr_way]   <= w_tag;
                data_q[w_idx][wr_way]  <= bus.in;
            end
            if (flush_go) scan_q <= '0;
            // The scan pointer only advances past a dirty line once its handshake completes.
            if (state_q == FLUSH_SCAN) begin
                if (scan_end) begin
                    bus.flush_done <= 1'b1;
                end else if (scan_dirty) begin
                    bus.evict_valid <= 1'b1;
                    bus.evict_addr  <= {tag_q[scan_set][scan_way], scan_set};
                    bus.evict_data  <= data_q[scan_set][scan_way];
                    dirty_q[scan_set][scan_way] <= 1'b0;
                end else begin
                    scan_q <= scan_q + (PTR_W+1)'(1);
                end
            end
            if (state_q == FLUSH_WAIT && handshake) scan_q <= scan_q + (PTR_W+1)'(1);
        end
    end
endmodule

// File: tb/tb_generic_n_way_wb_cache.sv
// tb/tb_generic_n_way_wb_cache.sv - directed self-checking bench for generic_n_way_wb_cache
module tb_generic_n_way_wb_cache;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;

    generic_n_way_wb_cache_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

    generic_n_way_wb_cache #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .ENTRIES(8), .WAYS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.re = 0; bus.read_addr = 0; bus.we = 0; bus.write_addr = 0;
        bus.in = 0; bus.flush = 0; bus.evict_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic write_word(input logic [7:0] a, input logic [7:0] d);
        bus.we = 1; bus.write_addr = a; bus.in = d;
        tick();
        bus.we = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.busy !== 1'b0 || bus.evict_valid !== 1'b0 || bus.hit !== 1'b0 ||
            bus.out !== 8'h00 || bus.flush_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b ev=%b hit=%b out=%h fd=%b expected all 0",
                     bus.busy, bus.evict_valid, bus.hit, bus.out, bus.flush_done);
        end
        bus.re = 1; bus.read_addr = 8'h05;
        tick();
        bus.re = 0;
        checks++;
        if (bus.hit !== 1'b0 || bus.out !== 8'h00 || bus.busy !== 1'b0 || bus.evict_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_read hit=%b out=%h busy=%b ev=%b expected 0/00/0/0",
                     bus.hit, bus.out, bus.busy, bus.evict_valid);
        end
    endtask

    task automatic test_write_read();
        do_reset();
        write_word(8'h05, 8'hAA);
        bus.re = 1; bus.read_addr = 8'h05;
        tick();
        checks++;
        if (bus.hit !== 1'b1 || bus.out !== 8'hAA) begin
            errors++;
            $display("FAIL read_hit hit=%b out=%h expected 1/aa", bus.hit, bus.out);
        end
        bus.read_addr = 8'h09;
        tick();
        bus.re = 0;
        checks++;
        if (bus.hit !== 1'b0 || bus.out !== 8'h00) begin
            errors++;
            $display("FAIL read_miss_same_set hit=%b out=%h expected 0/00", bus.hit, bus.out);
        end
    endtask

    task automatic test_evict_stall();
        do_reset();
        write_word(8'h01, 8'h11);
        write_word(8'h05, 8'h22);
        bus.re = 1; bus.read_addr = 8'h01;
        tick();
        bus.re = 0;
        write_word(8'h09, 8'h33);
        checks++;
        if (bus.evict_valid !== 1'b1 || bus.evict_addr !== 8'h05 || bus.evict_data !== 8'h22 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL evict_capture ev=%b addr=%h data=%h busy=%b expected 1/05/22/1",
                     bus.evict_valid, bus.evict_addr, bus.evict_data, bus.busy);
        end
        for (int c = 0; c < 3; c++) begin
            bus.we = (c == 0); bus.write_addr = 8'h0D; bus.in = 8'h77;
            bus.re = (c == 1); bus.read_addr = 8'h01;
            tick();
            checks++;
            if (bus.evict_valid !== 1'b1 || bus.evict_addr !== 8'h05 || bus.evict_data !== 8'h22 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL evict_hold cycle=%0d ev=%b addr=%h data=%h busy=%b expected 1/05/22/1",
                         c, bus.evict_valid, bus.evict_addr, bus.evict_data, bus.busy);
            end
            if (c == 1) begin
                checks++;
                if (bus.hit !== 1'b1 || bus.out !== 8'h11) begin
                    errors++;
                    $display("FAIL read_during_evict hit=%b out=%h expected 1/11", bus.hit, bus.out);
                end
            end
        end
        bus.we = 0; bus.re = 0;
        bus.evict_ready = 1;
        tick();
        bus.evict_ready = 0;
        checks++;
        if (bus.evict_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL evict_drain ev=%b busy=%b expected 0/0", bus.evict_valid, bus.busy);
        end
        bus.re = 1; bus.read_addr = 8'h0D;
        tick();
        bus.re = 0;
        checks++;
        if (bus.hit !== 1'b0) begin
            errors++;
            $display("FAIL write_ignored_in_evict hit=%b expected 0", bus.hit);
        end
    endtask

    task automatic test_lru_victim();
        do_reset();
        write_word(8'h01, 8'h11);
        write_word(8'h05, 8'h22);
        write_word(8'h09, 8'h33);
        checks++;
        if (bus.evict_valid !== 1'b1 || bus.evict_addr !== 8'h01 || bus.evict_data !== 8'h11) begin
            errors++;
            $display("FAIL lru_victim ev=%b addr=%h data=%h expected 1/01/11",
                     bus.evict_valid, bus.evict_addr, bus.evict_data);
        end
        bus.evict_ready = 1;
        tick();
        bus.evict_ready = 0;
        bus.re = 1; bus.read_addr = 8'h05;
        tick();
        bus.re = 0;
        checks++;
        if (bus.hit !== 1'b1 || bus.out !== 8'h22) begin
            errors++;
            $display("FAIL lru_survivor hit=%b out=%h expected 1/22", bus.hit, bus.out);
        end
    endtask

    task automatic test_read_before_write();
        do_reset();
        write_word(8'h02, 8'h44);
        bus.re = 1; bus.read_addr = 8'h02;
        bus.we = 1; bus.write_addr = 8'h02; bus.in = 8'h55;
        tick();
        bus.we = 0;
        checks++;
        if (bus.hit !== 1'b1 || bus.out !== 8'h44) begin
            errors++;
            $display("FAIL read_before_write hit=%b out=%h expected 1/44", bus.hit, bus.out);
        end
        tick();
        bus.re = 0;
        checks++;
        if (bus.hit !== 1'b1 || bus.out !== 8'h55) begin
            errors++;
            $display("FAIL read_after_write hit=%b out=%h expected 1/55", bus.hit, bus.out);
        end
    endtask

    task automatic test_flush();
        logic [7:0] exp_addr [3];
        logic [7:0] exp_data [3];
        int n_ev;
        int n_done;
        int cyc;
        exp_addr[0] = 8'h00; exp_addr[1] = 8'h03; exp_addr[2] = 8'h07;
        exp_data[0] = 8'hA0; exp_data[1] = 8'hA3; exp_data[2] = 8'hA7;
        do_reset();
        for (int i = 0; i < 3; i++) write_word(exp_addr[i], exp_data[i]);
        bus.evict_ready = 1;
        bus.flush = 1;
        tick();
        bus.flush = 0;
        n_ev = 0; n_done = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.evict_valid === 1'b1) begin
                checks++;
                if (n_ev >= 3 || bus.evict_addr !== exp_addr[n_ev % 3] || bus.evict_data !== exp_data[n_ev % 3]) begin
                    errors++;
                    $display("FAIL flush_evict idx=%0d addr=%h data=%h expected %h/%h",
                             n_ev, bus.evict_addr, bus.evict_data, exp_addr[n_ev % 3], exp_data[n_ev % 3]);
                end
                n_ev++;
            end
            if (bus.flush_done === 1'b1) n_done++;
            if (n_done > 0 && bus.busy === 1'b0) break;
        end
        tick();
        if (bus.flush_done === 1'b1) n_done++;
        checks++;
        if (n_ev !== 3 || n_done !== 1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_summary evictions=%0d done_pulses=%0d busy=%b expected 3/1/0", n_ev, n_done, bus.busy);
        end
        bus.re = 1; bus.read_addr = 8'h07;
        tick();
        bus.re = 0;
        checks++;
        if (bus.hit !== 1'b1 || bus.out !== 8'hA7) begin
            errors++;
            $display("FAIL read_after_flush hit=%b out=%h expected 1/a7", bus.hit, bus.out);
        end
        bus.flush = 1;
        tick();
        bus.flush = 0;
        cyc = 0; n_ev = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            cyc++;
            if (bus.evict_valid === 1'b1) n_ev++;
            if (bus.flush_done === 1'b1) break;
        end
        checks++;
        if (cyc !== 9 || n_ev !== 0 || bus.flush_done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL clean_flush cycles=%0d evictions=%0d done=%b busy=%b expected 9/0/1/0",
                     cyc, n_ev, bus.flush_done, bus.busy);
        end
        bus.evict_ready = 0;
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        write_word(8'h00, 8'hB0);
        bus.flush = 1;
        tick();
        bus.flush = 0;
        tick();
        checks++;
        if (bus.evict_valid !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_wait_entry ev=%b busy=%b expected 1/1", bus.evict_valid, bus.busy);
        end
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if (bus.evict_valid !== 1'b0 || bus.busy !== 1'b0 || bus.flush_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort ev=%b busy=%b fd=%b expected 0/0/0", bus.evict_valid, bus.busy, bus.flush_done);
        end
        bus.re = 1; bus.read_addr = 8'h00;
        tick();
        bus.re = 0;
        checks++;
        if (bus.hit !== 1'b0 || bus.out !== 8'h00) begin
            errors++;
            $display("FAIL read_after_abort hit=%b out=%h expected 0/00", bus.hit, bus.out);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_read();
        test_evict_stall();
        test_lru_victim();
        test_read_before_write();
        test_flush();
        test_reset_mid_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
